// File: rtl/lsu_mem_stage_if.sv
// Signal bundle for the memory-access stage: execute-side input handshake,
// write-back output handshake and the req/ack data bus.
interface lsu_mem_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  ctrl_mem;
   logic [63:0] result;
   logic [63:0] wdata;
   logic [4:0]  rd_in;

   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        out_err;

   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   // The stage itself.
   modport slave (
      input  in_valid, ctrl_mem, result, wdata, rd_in, out_ready, mem_ack, mem_rdata,
      output in_ready, out_valid, out_data, out_rd, out_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   // The surroundings: execute stage, write-back stage and memory.
   modport master (
      output in_valid, ctrl_mem, result, wdata, rd_in, out_ready, mem_ack, mem_rdata,
      input  in_ready, out_valid, out_data, out_rd, out_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// Single-entry memory-access stage. Holds one instruction at a time, issues at
// most one aligned load/store on the req/ack bus, and presents the write-back
// value through a valid/ready handshake. Bus waits are bounded by MAX_WAIT.
module lsu_mem_stage #(
   parameter int MAX_WAIT = 255
) (
   input logic          clk,
   input logic          rst,
   lsu_mem_stage_if.slave bus
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t        state_q, state_d;
   logic [4:0]    ctrl_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic [4:0]    rd_q;
   logic [63:0]   out_data_q, out_data_d;
   logic          out_err_q, out_err_d;
   logic [CW-1:0] wait_q, wait_d;

   logic          in_ready;
   logic          accept;
   logic          in_is_mem;
   logic [2:0]    in_mask;
   logic          in_misaligned;
   logic          is_req;
   logic          is_store;
   logic [63:0]   shifted;
   logic [63:0]   load_value;
   logic [7:0]    base_strb;

   assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign in_is_mem = bus.ctrl_mem[4] | bus.ctrl_mem[3];
   assign is_req    = (state_q == REQ);
   assign is_store  = ctrl_q[3] & ~ctrl_q[4];

   // Offset bits that must be zero for the incoming access size.
   always_comb begin
      in_mask = 3'b000;
      case (bus.ctrl_mem[1:0])
         2'd0:    in_mask = 3'b000;
         2'd1:    in_mask = 3'b001;
         2'd2:    in_mask = 3'b011;
         default: in_mask = 3'b111;
      endcase
      in_misaligned = |(bus.result[2:0] & in_mask);
   end

   // Load data: move the addressed bytes to the bottom and extend by size.
   always_comb begin
      shifted    = bus.mem_rdata >> {addr_q[2:0], 3'b000};
      load_value = shifted;
      case (ctrl_q[1:0])
         2'd0:    load_value = ctrl_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         2'd1:    load_value = ctrl_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         2'd2:    load_value = ctrl_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: load_value = shifted;
      endcase
   end

   // Unshifted byte strobe for the latched access size.
   always_comb begin
      base_strb = 8'h00;
      case (ctrl_q[1:0])
         2'd0:    base_strb = 8'h01;
         2'd1:    base_strb = 8'h03;
         2'd2:    base_strb = 8'h0F;
         default: base_strb = 8'hFF;
      endcase
   end

   // Next state, result capture and wait counting; a new accept overrides the
   // HOLD path so back-to-back instructions go straight to their next state.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      wait_d     = wait_q;
      case (state_q)
         IDLE: state_d = IDLE;
         REQ: begin
            if (bus.mem_ack) begin
               state_d    = HOLD;
               out_data_d = ctrl_q[4] ? load_value : 64'd0;
               out_err_d  = 1'b0;
               wait_d     = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d    = HOLD;
               out_data_d = 64'd0;
               out_err_d  = 1'b1;
               wait_d     = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         HOLD: begin
            if (bus.out_ready && !bus.in_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         wait_d = '0;
         if (!in_is_mem) begin
            state_d    = HOLD;
            out_data_d = bus.result;
            out_err_d  = 1'b0;
         end else if (in_misaligned) begin
            state_d    = HOLD;
            out_data_d = 64'd0;
            out_err_d  = 1'b1;
         end else begin
            state_d = REQ;
         end
      end
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_data_q <= 64'd0;
         out_err_q  <= 1'b0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_err_q  <= out_err_d;
         wait_q     <= wait_d;
      end
   end

   // Instruction latch, loaded only on accept so nothing moves while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q  <= 5'd0;
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
         rd_q    <= 5'd0;
      end else if (accept) begin
         ctrl_q  <= bus.ctrl_mem;
         addr_q  <= bus.result;
         wdata_q <= bus.wdata;
         rd_q    <= bus.rd_in;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_err   = out_err_q;
   assign bus.mem_req   = is_req;
   assign bus.mem_we    = is_req & is_store;
   assign bus.mem_addr  = is_req ? {addr_q[63:3], 3'b000} : 64'd0;
   assign bus.mem_wstrb = is_req ? (base_strb << addr_q[2:0]) : 8'h00;
   assign bus.mem_wdata = (is_req && is_store) ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected write-back results are queued
// when an instruction is accepted and compared when the stage hands them off.
module tb_lsu_mem_stage;

   localparam int MAX_WAIT = 255;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   lsu_mem_stage_if bus ();

   lsu_mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;

   int          ack_delay = -1;
   logic        force_ack = 1'b0;
   int          req_cycles = 0;
   int          req_total = 0;
   int          last_req_len = 0;
   logic [63:0] exp_addr = 64'd0;
   logic        exp_we = 1'b0;
   logic [7:0]  exp_wstrb = 8'h00;
   logic [63:0] exp_wdata = 64'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction and hold it until accepted, queueing its result.
   task automatic applyStimulus(input logic [4:0] ctrl, input logic [63:0] res,
                                input logic [63:0] wd, input logic [4:0] rd,
                                input logic [63:0] exp_data, input logic exp_err,
                                output int waited);
      exp_t e;
      bit   done;
      bus.ctrl_mem = ctrl;
      bus.result   = res;
      bus.wdata    = wd;
      bus.rd_in    = rd;
      bus.in_valid = 1'b1;
      waited = 0;
      done   = 0;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1;
         end else begin
            waited++;
            if (waited > 2000) begin
               checkOutput("accept_timeout", 64'd0, 64'd1);
               done = 1;
            end
         end
      end
      e.data = exp_data;
      e.rd   = rd;
      e.err  = exp_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory model: acks the request ack_delay cycles after it rises and checks
   // the bus fields at that moment; force_ack injects a stray ack.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (ack_delay >= 0 && req_cycles == ack_delay) begin
            bus.mem_ack = 1'b1;
            checkOutput("mem_addr", bus.mem_addr, exp_addr);
            checkOutput("mem_we", 64'(bus.mem_we), 64'(exp_we));
            checkOutput("mem_wstrb", 64'(bus.mem_wstrb), 64'(exp_wstrb));
            if (exp_we) begin
               logic [63:0] mask;
               for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{exp_wstrb[b]}};
               checkOutput("mem_wdata", bus.mem_wdata & mask, exp_wdata & mask);
            end
         end else begin
            bus.mem_ack = force_ack;
         end
         req_cycles++;
         req_total++;
      end else begin
         if (req_cycles != 0) last_req_len = req_cycles;
         req_cycles  = 0;
         bus.mem_ack = force_ack;
      end
   end

   // Write-back monitor: every completed handoff must match the queue head.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("out_data", bus.out_data, mon_e.data);
            checkOutput("out_rd", 64'(bus.out_rd), 64'(mon_e.rd));
            checkOutput("out_err", 64'(bus.out_err), 64'(mon_e.err));
         end
      end
   end

   // Directed sequence.
   initial begin
      int w;
      int r0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.ctrl_mem  = 5'd0;
      bus.result    = 64'd0;
      bus.wdata     = 64'd0;
      bus.rd_in     = 5'd0;
      bus.out_ready = 1'b1;
      bus.mem_rdata = 64'd0;
      bus.mem_ack   = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
      checkOutput("rst_out_data", bus.out_data, 64'd0);
      checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
      checkOutput("rst_wstrb", 64'(bus.mem_wstrb), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      settle(1);

      // ALU op: one-cycle latency and no bus traffic.
      r0 = req_total;
      applyStimulus(5'b00000, 64'h1234, 64'd0, 5'd5, 64'h1234, 1'b0, w);
      @(negedge clk);
      checkOutput("add_latency", 64'(bus.out_valid), 64'd1);
      settle(3);
      checkOutput("add_no_req", 64'(req_total - r0), 64'd0);

      // LB signed / unsigned at offset 3.
      bus.mem_rdata = 64'h00000000_80FF0000;
      ack_delay = 2;
      exp_addr  = 64'h80000000;
      exp_we    = 1'b0;
      exp_wstrb = 8'h08;
      applyStimulus(5'b10000, 64'h80000003, 64'd0, 5'd6, 64'hFFFFFFFFFFFFFF80, 1'b0, w);
      settle(8);
      applyStimulus(5'b10100, 64'h80000003, 64'd0, 5'd7, 64'h80, 1'b0, w);
      settle(8);

      // SH at offset 6.
      ack_delay = 1;
      exp_we    = 1'b1;
      exp_wstrb = 8'hC0;
      exp_wdata = 64'hBEEF0000_00000000;
      applyStimulus(5'b01001, 64'h80000006, 64'hBEEF, 5'd8, 64'd0, 1'b0, w);
      settle(8);

      // LH signed at offset 2, LW unsigned at offset 4, LD with both op bits.
      ack_delay = 0;
      exp_we    = 1'b0;
      bus.mem_rdata = 64'hF0000000_80010000;
      exp_addr  = 64'h1000;
      exp_wstrb = 8'h0C;
      applyStimulus(5'b10001, 64'h1002, 64'd0, 5'd10, 64'hFFFFFFFFFFFF8001, 1'b0, w);
      settle(6);
      exp_wstrb = 8'hF0;
      applyStimulus(5'b10110, 64'h1004, 64'd0, 5'd11, 64'h00000000F0000000, 1'b0, w);
      settle(6);
      bus.mem_rdata = 64'h01234567_89ABCDEF;
      exp_addr  = 64'h100;
      exp_wstrb = 8'hFF;
      applyStimulus(5'b11111, 64'h100, 64'd0, 5'd12, 64'h01234567_89ABCDEF, 1'b0, w);
      settle(6);

      // SW at offset 4 and SD at offset 0.
      exp_we    = 1'b1;
      exp_addr  = 64'h2000;
      exp_wstrb = 8'hF0;
      exp_wdata = 64'hCAFEF00D_00000000;
      applyStimulus(5'b01010, 64'h2004, 64'hCAFEF00D, 5'd13, 64'd0, 1'b0, w);
      settle(6);
      exp_wstrb = 8'hFF;
      exp_wdata = 64'h11223344_55667788;
      applyStimulus(5'b01011, 64'h2000, 64'h11223344_55667788, 5'd14, 64'd0, 1'b0, w);
      settle(6);

      // Misaligned LW and SD: error one cycle after accept, no request.
      r0 = req_total;
      applyStimulus(5'b10010, 64'h80000002, 64'd0, 5'd15, 64'd0, 1'b1, w);
      @(negedge clk);
      checkOutput("misal_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("misal_err", 64'(bus.out_err), 64'd1);
      settle(3);
      applyStimulus(5'b01011, 64'h2004, 64'd1, 5'd16, 64'd0, 1'b1, w);
      settle(3);
      checkOutput("misal_no_req", 64'(req_total - r0), 64'd0);

      // Bus timeout, stalled write-back, then a back-to-back accept.
      ack_delay = -1;
      bus.out_ready = 1'b0;
      applyStimulus(5'b10010, 64'h3000, 64'd0, 5'd17, 64'd0, 1'b1, w);
      r0 = 0;
      while (!bus.out_valid && r0 < MAX_WAIT + 50) begin
         @(negedge clk);
         r0++;
      end
      checkOutput("timeout_seen", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("hold_data", bus.out_data, 64'd0);
         checkOutput("hold_err", 64'(bus.out_err), 64'd1);
         checkOutput("hold_rd", 64'(bus.out_rd), 64'd17);
         checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
      end
      checkOutput("timeout_len", 64'(last_req_len), 64'(MAX_WAIT));
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      applyStimulus(5'b00000, 64'h77, 64'd0, 5'd3, 64'h77, 1'b0, w);
      checkOutput("b2b_wait", 64'(w), 64'd0);
      settle(3);

      // Reset while a request is outstanding; a late ack must be ignored.
      applyStimulus(5'b10011, 64'h4000, 64'd0, 5'd9, 64'd0, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("req_before_rst", 64'(bus.mem_req), 64'd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_req_drop", 64'(bus.mem_req), 64'd0);
      checkOutput("rst_in_ready2", 64'(bus.in_ready), 64'd1);
      if (sb.size() != 0) void'(sb.pop_back());
      force_ack = 1'b1;
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("late_ack_no_valid", 64'(bus.out_valid), 64'd0);
      end

      settle(2);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage that sits directly downstream of the execute stage. It consumes the execute result (effective address or ALU value), the store data and the memory control bits. It performs at most one aligned load or store per instruction over a simple req/ack data bus, then hands the write-back value and destination register to the WB stage through a valid/ready handshake. Single-entry, non-pipelined: one instruction in flight at a time.

Parameters:
MAX_WAIT, 255, cycles mem_req may stay high without mem_ack before the access is aborted with an error.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  execute stage presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
ctrl_mem  input  5  [4] load, [3] store, [2] unsigned load, [1:0] size (0=B, 1=H, 2=W, 3=D)
result  input  64  execute result: the address for load/store, otherwise the write-back value
wdata  input  64  store data, right-aligned
rd_in  input  5  destination register
out_valid  output  1  write-back data valid
out_ready  input  1  WB stage accepts
out_data  output  64  load data (extended), ALU result, or 0 for a store
out_rd  output  5  destination register, passed through
out_err  output  1  misaligned access or bus timeout; qualified by out_valid
mem_req  output  1  bus request
mem_we  output  1  1 = store
mem_addr  output  64  doubleword-aligned address: {result[63:3],3'b000}
mem_wdata  output  64  store data shifted to its byte lane
mem_wstrb  output  8  byte write strobes
mem_ack  input  1  bus completion; read data valid in the same cycle
mem_rdata  input  64  read doubleword

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous and active-high.
- Reset value: state IDLE; in_ready=1; all other outputs 0; wait counter 0.
- Handshake: in_ready = (state==IDLE) | (state==HOLD & out_ready). An input is accepted when in_valid & in_ready.
- On accept, latch ctrl_mem, result, wdata and rd_in. Latched values are not re-sampled while busy.
- States: IDLE, REQ, HOLD.
- Accept a non-memory op (ctrl_mem[4:3]==0): next state HOLD, out_data=result, out_err=0. Latency 1 cycle.
- Accept with both ctrl_mem[4] and ctrl_mem[3] set: treat as a load.
- Misalignment: the address offset result[2:0] must be a multiple of 2^size. If it is not: next state HOLD, out_err=1, out_data=0. No bus request is issued.
- Aligned memory op: next state REQ.
- REQ: mem_req=1, and mem_we/mem_addr/mem_wdata/mem_wstrb are held stable until mem_ack.
  - The wait counter increments each cycle without ack.
  - On mem_ack (possible in the first REQ cycle): next state HOLD, mem_req=0 next cycle, counter cleared.
  - If the counter reaches MAX_WAIT with no ack: next state HOLD, out_err=1, out_data=0, mem_req dropped.
- Store encoding: mem_wstrb = ((1<<2^size)-1) << result[2:0]; mem_wdata = wdata << (8*result[2:0]). Bytes outside the strobe are don't-care. out_data=0 for stores.
- Load extraction: shifted = mem_rdata >> (8*offset). Take the low 8/16/32/64 bits; sign-extend unless ctrl_mem[2]=1, then zero-extend. A D-size load ignores ctrl_mem[2]. The result is captured on mem_ack.
- HOLD: out_valid=1. out_data, out_rd and out_err stay stable until out_ready.
  - out_ready & in_valid: accept the new instruction in the same cycle (back-to-back, no bubble).
  - out_ready without in_valid: go to IDLE.
- mem_ack outside REQ is ignored.
- Reset during REQ: mem_req=0 on the next cycle. A late ack after reset is ignored, and no out_valid is produced for the aborted instruction.

Test Plan:
- ADD: result=0x1234, ctrl_mem=0, rd_in=5, out_ready=1 -> out_valid the next cycle with out_data=0x1234, out_rd=5, out_err=0, and mem_req never asserted.
- LB signed: result=0x80000003, mem_rdata=0x00000000_80FF0000, ack after 2 cycles -> mem_addr=0x80000000, out_data=0xFFFFFFFFFFFFFF80. Repeat with ctrl_mem[2]=1 -> out_data=0x80.
- SH: result=0x80000006, wdata=0xBEEF -> mem_we=1, mem_wstrb=0xC0, mem_wdata[63:48]=0xBEEF, out_data=0 after ack.
- Misaligned LW at 0x80000002 -> no mem_req, out_valid with out_err=1 one cycle after accept.
- Timeout and back-to-back: mem_ack never asserted -> mem_req drops after MAX_WAIT cycles and out_err=1. Then hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 -> the next op is accepted in the same cycle.
- Reset after 3 cycles in REQ -> mem_req=0 the next cycle, in_ready=1; a late ack is ignored and out_valid stays 0.
